// File: rtl/microc_pila.sv
// Single-cycle CPU datapath: PC, regfile, ALU, write-back mux and return-address stack (MICROC_R0_ZERO_EN: r0 hard-wired 0).
// All state updates on the clock edge after inputs settle; no stalls, one instruction per cycle.
module microc_pila #(
   parameter int DW     = 8,
   parameter int PCW    = 10,
   parameter int RAW    = 4,
   parameter int IW     = 16,
   parameter int SDEPTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [IW-1:0]             instr,
   input  logic                      s_skip,
   input  logic                      s_inc,
   input  logic                      s_inm,
   input  logic                      we,
   input  logic [2:0]                ALUOp,
   input  logic                      s_call,
   input  logic                      s_ret,
   output logic [PCW-1:0]            pc,
   output logic [5:0]                opcode,
   output logic                      zero,
   output logic                      carry,
   output logic [$clog2(SDEPTH):0]   stk_level,
   output logic                      stk_err
);

   localparam int NREG = 2**RAW;
   localparam int LW   = $clog2(SDEPTH) + 1;
   localparam int SAW  = LW - 1;

   logic [PCW-1:0] pc_q, pc_d;
   logic [DW-1:0]  regs_q [NREG];
   logic [DW-1:0]  regs_d [NREG];
   logic [PCW-1:0] stk_q [SDEPTH];
   logic [PCW-1:0] stk_d [SDEPTH];
   logic [LW-1:0]  lvl_q, lvl_d;
   logic           err_q, err_d;
   logic           zero_q, zero_d;
   logic           carry_q, carry_d;

   logic [PCW-1:0] target, pc_one, pc_inc, pc_skip;
   logic [RAW-1:0] ra1, ra2, wa3;
   logic [DW-1:0]  imm, rd1, rd2, alu_y, wd3;
   logic           alu_c;
   logic [DW:0]    sum, one_w;
   logic [LW-1:0]  lvl_m1;
   logic           stk_full, stk_empty;

   assign target  = instr[PCW-1:0];
   assign ra1     = instr[RAW-1:0];
   assign ra2     = instr[2*RAW-1:RAW];
   assign wa3     = instr[3*RAW-1:2*RAW];
   assign imm     = instr[DW+RAW-1:RAW];
   assign rd1     = regs_q[ra1];
   assign rd2     = regs_q[ra2];
   assign one_w   = {{DW{1'b0}}, 1'b1};
   assign pc_one  = {{(PCW-1){1'b0}}, 1'b1};
   assign pc_skip = {{(PCW-1){1'b0}}, s_skip};
   assign pc_inc  = pc_q + pc_one;
   assign lvl_m1  = lvl_q - LW'(1);
   assign stk_full  = (lvl_q == LW'(SDEPTH));
   assign stk_empty = (lvl_q == '0);

   // Subtraction and negation share the adder so carry is the true DW-bit carry-out.
   always_comb begin
      sum   = '0;
      alu_y = rd1;
      alu_c = 1'b0;
      case (ALUOp)
         3'b000: alu_y = rd1;
         3'b001: alu_y = ~rd1;
         3'b010: begin
            sum = {1'b0, rd1} + {1'b0, rd2};
            {alu_c, alu_y} = sum;
         end
         3'b011: begin
            sum = {1'b0, rd1} + {1'b0, ~rd2} + one_w;
            {alu_c, alu_y} = sum;
         end
         3'b100: alu_y = rd1 & rd2;
         3'b101: alu_y = rd1 | rd2;
         3'b110: begin
            sum = {1'b0, ~rd1} + one_w;
            {alu_c, alu_y} = sum;
         end
         default: begin
            sum = {1'b0, ~rd2} + one_w;
            {alu_c, alu_y} = sum;
         end
      endcase
   end

   assign wd3 = s_inm ? imm : alu_y;

   always_comb begin
      pc_d  = pc_inc;
      lvl_d = lvl_q;
      err_d = err_q;
      stk_d = stk_q;
      if (s_call && s_ret) begin
         err_d = 1'b1;
      end else if (s_ret) begin
         if (!stk_empty) begin
            pc_d  = stk_q[lvl_m1[SAW-1:0]];
            lvl_d = lvl_m1;
         end else begin
            err_d = 1'b1;
         end
      end else if (s_call) begin
         if (!stk_full) begin
            stk_d[lvl_q[SAW-1:0]] = pc_inc;
            pc_d  = target;
            lvl_d = lvl_q + LW'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (s_inc) begin
         pc_d = pc_inc + pc_skip;
      end else begin
         pc_d = pc_q + target;
      end
   end

   always_comb begin
      regs_d  = regs_q;
      zero_d  = zero_q;
      carry_d = carry_q;
`ifdef MICROC_R0_ZERO_EN
      if (we && (wa3 != '0)) regs_d[wa3] = wd3;
`else
      if (we) regs_d[wa3] = wd3;
`endif
      if (we && !s_inm) begin
         zero_d  = (alu_y == '0);
         carry_d = alu_c;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q    <= '0;
         regs_q  <= '{default: '0};
         stk_q   <= '{default: '0};
         lvl_q   <= '0;
         err_q   <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         regs_q  <= regs_d;
         stk_q   <= stk_d;
         lvl_q   <= lvl_d;
         err_q   <= err_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

   assign pc        = pc_q;
   assign opcode    = instr[IW-1:IW-6];
   assign zero      = zero_q;
   assign carry     = carry_q;
   assign stk_level = lvl_q;
   assign stk_err   = err_q;

endmodule

// File: tb/tb_microc_pila.sv
// Directed bench for microc_pila: control flow, return stack, ALU flags, async reset.
module tb_microc_pila;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr;
   logic        s_skip, s_inc, s_inm, we, s_call, s_ret;
   logic [2:0]  ALUOp;
   logic [9:0]  pc;
   logic [5:0]  opcode;
   logic        zero, carry, stk_err;
   logic [2:0]  stk_level;

   int n_vec = 0;
   int n_err = 0;

   microc_pila dut (
      .clk(clk), .reset(reset), .instr(instr), .s_skip(s_skip), .s_inc(s_inc),
      .s_inm(s_inm), .we(we), .ALUOp(ALUOp), .s_call(s_call), .s_ret(s_ret),
      .pc(pc), .opcode(opcode), .zero(zero), .carry(carry),
      .stk_level(stk_level), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic exec(input logic [15:0] i, input logic inc, input logic skip, input logic inm,
                       input logic w, input logic [2:0] op, input logic call, input logic ret);
      instr = i; s_inc = inc; s_skip = skip; s_inm = inm; we = w; ALUOp = op;
      s_call = call; s_ret = ret;
      @(posedge clk);
      #1;
   endtask

   task automatic jump(input logic [9:0] t);  exec({6'h0, t}, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0); endtask
   task automatic step(input logic skip);     exec(16'h0, 1'b1, skip, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0); endtask
   task automatic call_to(input logic [9:0] t); exec({6'h0, t}, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0); endtask
   task automatic ret_op();                   exec(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1); endtask
   task automatic imm_ld(input logic [15:0] i); exec(i, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0); endtask
   task automatic alu(input logic [15:0] i, input logic [2:0] op, input logic w);
      exec(i, 1'b1, 1'b0, 1'b0, w, op, 1'b0, 1'b0);
   endtask

   task automatic chk_flow(input string tag, input logic [9:0] epc, input logic [2:0] elvl, input logic eerr);
      check({tag, ".pc"}, 32'(pc), 32'(epc));
      check({tag, ".lvl"}, 32'(stk_level), 32'(elvl));
      check({tag, ".err"}, 32'(stk_err), 32'(eerr));
   endtask

   task automatic chk_flags(input string tag, input logic ez, input logic ec);
      check({tag, ".zero"}, 32'(zero), 32'(ez));
      check({tag, ".carry"}, 32'(carry), 32'(ec));
   endtask

   initial begin
      reset = 1'b0;
      instr = '0; s_skip = 0; s_inc = 1; s_inm = 0; we = 0; ALUOp = 3'b000; s_call = 0; s_ret = 0;
      #12;
      chk_flow("por", 10'h000, 3'd0, 1'b0);
      chk_flags("por", 1'b0, 1'b0);
      @(negedge clk) reset = 1'b1;

      // Relative jump, call/return, skip, wraparound.
      jump(10'h005);         chk_flow("jmp5", 10'h005, 3'd0, 1'b0);
      call_to(10'h100);      chk_flow("call1", 10'h100, 3'd1, 1'b0);
      ret_op();              chk_flow("ret1", 10'h006, 3'd0, 1'b0);
      step(1'b1);            check("skip.pc", 32'(pc), 32'h008);
      jump(10'h3F7);         check("jmp3ff.pc", 32'(pc), 32'h3FF);
      step(1'b0);            check("wrapinc.pc", 32'(pc), 32'h000);
      jump(10'h005);
      jump(10'h3FE);         check("wraprel.pc", 32'(pc), 32'h003);

      // Nested calls up to overflow, then unwind past empty.
      call_to(10'h010);      chk_flow("nc1", 10'h010, 3'd1, 1'b0);
      call_to(10'h020);      chk_flow("nc2", 10'h020, 3'd2, 1'b0);
      call_to(10'h030);      chk_flow("nc3", 10'h030, 3'd3, 1'b0);
      call_to(10'h040);      chk_flow("nc4", 10'h040, 3'd4, 1'b0);
      call_to(10'h050);      chk_flow("nc5ovf", 10'h041, 3'd4, 1'b1);
      ret_op();              chk_flow("nr1", 10'h031, 3'd3, 1'b1);
      ret_op();              chk_flow("nr2", 10'h021, 3'd2, 1'b1);
      ret_op();              chk_flow("nr3", 10'h011, 3'd1, 1'b1);
      ret_op();              chk_flow("nr4", 10'h004, 3'd0, 1'b1);
      ret_op();              chk_flow("nr5udf", 10'h005, 3'd0, 1'b1);

      // Build pc=0x37, level=2, flags set, then reset asynchronously mid-cycle.
      call_to(10'h100);
      call_to(10'h200);
      alu(16'h0900, 3'b011, 1'b1);   chk_flags("sub00", 1'b1, 1'b1);
      jump(10'h236);                 chk_flow("prerst", 10'h037, 3'd2, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk_flow("arst", 10'h000, 3'd0, 1'b0);
      chk_flags("arst", 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk) reset = 1'b1;

      exec(16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
      chk_flow("callret", 10'h001, 3'd0, 1'b1);

      // ALU and flags; registers verified indirectly through the zero flag.
      imm_ld(16'h0F00);              chk_flags("immF0", 1'b0, 1'b0);
      imm_ld(16'h0200);
      alu(16'h032F, 3'b010, 1'b1);   chk_flags("add", 1'b0, 1'b1);
      imm_ld(16'h0100);              chk_flags("immhold", 1'b0, 1'b1);
      alu(16'h0613, 3'b011, 1'b1);   chk_flags("sub_r3", 1'b1, 1'b1);
      alu(16'h0702, 3'b110, 1'b1);   chk_flags("negA", 1'b0, 1'b0);
      alu(16'h0800, 3'b111, 1'b1);   chk_flags("negB0", 1'b1, 1'b1);
      alu(16'h081F, 3'b100, 1'b0);   chk_flags("and_nowe", 1'b1, 1'b1);
      alu(16'h081F, 3'b100, 1'b1);   chk_flags("and", 1'b0, 1'b0);
      alu(16'h0A00, 3'b101, 1'b1);   chk_flags("or0", 1'b1, 1'b0);
      imm_ld(16'h0050);
      alu(16'h0B00, 3'b000, 1'b1);
`ifdef MICROC_R0_ZERO_EN
      chk_flags("r0read", 1'b1, 1'b0);
`else
      chk_flags("r0read", 1'b0, 1'b0);
`endif
      instr = 16'hA800;
      #1;
      check("opcode", 32'(opcode), 32'h2A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
